// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multi-cycle control path:
// opcode constants, FSM state encoding, instruction classes,
// PC source select and fault cause encodings.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // FETCH must stay at zero: state_o reads as FETCH while reset is held.
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CL_NONE    = 4'd0,
        CL_OP      = 4'd1,
        CL_OP_IMM  = 4'd2,
        CL_LUI     = 4'd3,
        CL_AUIPC   = 4'd4,
        CL_JAL     = 4'd5,
        CL_JALR    = 4'd6,
        CL_BRANCH  = 4'd7,
        CL_LOAD    = 4'd8,
        CL_STORE   = 4'd9,
        CL_FENCE   = 4'd10,
        CL_SYSTEM  = 4'd11,
        CL_ILLEGAL = 4'd12
    } iclass_e;

    typedef enum logic [1:0] {
        PC_PLUS4   = 2'd0,
        PC_IMM     = 2'd1,
        PC_RS1_IMM = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'd0,
        FLT_ILLEGAL = 2'd1,
        FLT_TIMEOUT = 2'd2,
        FLT_SYSTEM  = 2'd3
    } fault_e;

    // Classes that finish through the register-file write stage.
    function automatic logic is_wb_class(input iclass_e cls);
        return (cls == CL_OP)  || (cls == CL_OP_IMM) || (cls == CL_LUI) ||
               (cls == CL_AUIPC) || (cls == CL_JAL) || (cls == CL_JALR) ||
               (cls == CL_LOAD);
    endfunction

endpackage

// File: rtl/core_ctrl_op_classify.sv
// op_classify: purely combinational map from the 7-bit major opcode
// to an instruction class. Anything not listed is CL_ILLEGAL.
module op_classify
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode_i,
    output iclass_e    class_o
);

    // Decode the major opcode into its class.
    always_comb begin
        class_o = CL_ILLEGAL;
        case (opcode_i)
            OPC_OP:       class_o = CL_OP;
            OPC_OP_IMM:   class_o = CL_OP_IMM;
            OPC_LUI:      class_o = CL_LUI;
            OPC_AUIPC:    class_o = CL_AUIPC;
            OPC_JAL:      class_o = CL_JAL;
            OPC_JALR:     class_o = CL_JALR;
            OPC_BRANCH:   class_o = CL_BRANCH;
            OPC_LOAD:     class_o = CL_LOAD;
            OPC_STORE:    class_o = CL_STORE;
            OPC_MISC_MEM: class_o = CL_FENCE;
            OPC_SYSTEM:   class_o = CL_SYSTEM;
            default:      class_o = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle RV32I control FSM.
// Build option: CORE_CTRL_TIMEOUT_EN adds a bus watchdog that halts with
// a timeout fault after TIMEOUT_CYCLES unacknowledged request cycles.
//
// state     | meaning
// ----------+-------------------------------------------------------
// FETCH     | imem request held until ack; ack loads the IR
// DECODE    | classify opcode, register class, trap illegal/SYSTEM
// EXECUTE   | branches and FENCE retire here; others move on
// MEMORY    | dmem request held until ack; stores retire on ack
// WRITEBACK | register-file write, PC update and retire
// HALT      | absorbing until reset; fault_o holds the cause
module core_ctrl
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instruction_i,
    input  logic        branch_taken_i,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ack_i,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic        rf_we_o,
    output logic        retire_o,
    output logic [2:0]  state_o,
    output logic [1:0]  fault_o
);

    state_e  r_state;
    state_e  w_next_state;
    iclass_e r_class;
    iclass_e w_class;
    fault_e  r_fault;
    fault_e  w_next_fault;
    pc_sel_e w_pc_sel;
    logic    w_waiting;
    logic    w_timeout;
    logic    w_unused_ir;

    // Only the major opcode steers control; the remaining fields feed the datapath.
    assign w_unused_ir = ^instruction_i[31:7];

    op_classify u_op_classify (
        .opcode_i (instruction_i[6:0]),
        .class_o  (w_class)
    );

    assign w_waiting = ((r_state == ST_FETCH)  && !imem_ack_i) ||
                       ((r_state == ST_MEMORY) && !dmem_ack_i);

`ifdef CORE_CTRL_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_tmo_cnt;

    // The cycle that would make the count reach TIMEOUT_CYCLES is the last one waited.
    assign w_timeout = w_waiting && (r_tmo_cnt == TC_LAST);

    // Count consecutive unacknowledged request cycles within one state visit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
        end else if (w_waiting && (w_next_state == r_state)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    logic w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = w_waiting ^ (TIMEOUT_CYCLES == 0);
`endif

    // Next-state and fault-cause selection.
    always_comb begin
        w_next_state = r_state;
        w_next_fault = r_fault;
        case (r_state)
            ST_FETCH: begin
                if (imem_ack_i) begin
                    w_next_state = ST_DECODE;
                end else if (w_timeout) begin
                    w_next_state = ST_HALT;
                    w_next_fault = FLT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (w_class == CL_ILLEGAL) begin
                    w_next_state = ST_HALT;
                    w_next_fault = FLT_ILLEGAL;
                end else if (w_class == CL_SYSTEM) begin
                    w_next_state = ST_HALT;
                    w_next_fault = FLT_SYSTEM;
                end else begin
                    w_next_state = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if ((r_class == CL_BRANCH) || (r_class == CL_FENCE)) begin
                    w_next_state = ST_FETCH;
                end else if ((r_class == CL_LOAD) || (r_class == CL_STORE)) begin
                    w_next_state = ST_MEMORY;
                end else begin
                    w_next_state = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                if (dmem_ack_i) begin
                    w_next_state = (r_class == CL_STORE) ? ST_FETCH : ST_WRITEBACK;
                end else if (w_timeout) begin
                    w_next_state = ST_HALT;
                    w_next_fault = FLT_TIMEOUT;
                end
            end
            ST_WRITEBACK: w_next_state = ST_FETCH;
            ST_HALT:      w_next_state = ST_HALT;
            default:      w_next_state = ST_HALT;
        endcase
    end

    // State, fault cause and latched instruction class.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_FETCH;
            r_fault <= FLT_NONE;
            r_class <= CL_NONE;
        end else begin
            r_state <= w_next_state;
            r_fault <= w_next_fault;
            if (r_state == ST_DECODE) begin
                r_class <= w_class;
            end
        end
    end

    // Strobes and requests from the registered state; reset forces everything low.
    always_comb begin
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        ir_we_o    = 1'b0;
        pc_we_o    = 1'b0;
        rf_we_o    = 1'b0;
        retire_o   = 1'b0;
        w_pc_sel   = PC_PLUS4;
        if (!rst_i) begin
            case (r_state)
                ST_FETCH: begin
                    imem_req_o = 1'b1;
                    ir_we_o    = imem_ack_i;
                end
                ST_EXECUTE: begin
                    if (r_class == CL_BRANCH) begin
                        pc_we_o  = 1'b1;
                        retire_o = 1'b1;
                        w_pc_sel = branch_taken_i ? PC_IMM : PC_PLUS4;
                    end else if (r_class == CL_FENCE) begin
                        pc_we_o  = 1'b1;
                        retire_o = 1'b1;
                    end
                end
                ST_MEMORY: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = (r_class == CL_STORE);
                    if (dmem_ack_i && (r_class == CL_STORE)) begin
                        pc_we_o  = 1'b1;
                        retire_o = 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    rf_we_o  = is_wb_class(r_class);
                    pc_we_o  = 1'b1;
                    retire_o = 1'b1;
                    if (r_class == CL_JAL) begin
                        w_pc_sel = PC_IMM;
                    end else if (r_class == CL_JALR) begin
                        w_pc_sel = PC_RS1_IMM;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_sel_o = w_pc_sel;
    assign state_o  = rst_i ? ST_FETCH : r_state;
    assign fault_o  = rst_i ? FLT_NONE : r_fault;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl. Each cycle packs all outputs into one
// 14-bit word {state, fault, imem_req, dmem_req, dmem_we, ir_we, pc_we,
// pc_sel, rf_we, retire} and compares it with a hand-written constant.
// Per-cycle drive word is {rst, imem_ack, dmem_ack, branch_taken}.
module tb_core_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] instruction_i = 32'h0;
    logic        branch_taken_i = 1'b0;
    logic        imem_ack_i = 1'b0;
    logic        dmem_ack_i = 1'b0;
    logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o;
    logic        pc_we_o, rf_we_o, retire_o;
    logic [1:0]  pc_sel_o, fault_o;
    logic [2:0]  state_o;

    int total = 0;
    int bad   = 0;

    core_ctrl #(.TIMEOUT_CYCLES(15)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instruction_i  (instruction_i),
        .branch_taken_i (branch_taken_i),
        .imem_req_o     (imem_req_o),
        .imem_ack_i     (imem_ack_i),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_ack_i     (dmem_ack_i),
        .ir_we_o        (ir_we_o),
        .pc_we_o        (pc_we_o),
        .pc_sel_o       (pc_sel_o),
        .rf_we_o        (rf_we_o),
        .retire_o       (retire_o),
        .state_o        (state_o),
        .fault_o        (fault_o)
    );

    always #5 clk_i = ~clk_i;

    logic [13:0] obs;
    assign obs = {state_o, fault_o, imem_req_o, dmem_req_o, dmem_we_o,
                  ir_we_o, pc_we_o, pc_sel_o, rf_we_o, retire_o};

    localparam logic [13:0] X_RST  = 14'd0;
    localparam logic [13:0] X_F0   = {3'd0, 2'd0, 5'b10000, 2'd0, 2'b00};
    localparam logic [13:0] X_FA   = {3'd0, 2'd0, 5'b10010, 2'd0, 2'b00};
    localparam logic [13:0] X_D    = {3'd1, 2'd0, 5'b00000, 2'd0, 2'b00};
    localparam logic [13:0] X_E    = {3'd2, 2'd0, 5'b00000, 2'd0, 2'b00};
    localparam logic [13:0] X_EBT  = {3'd2, 2'd0, 5'b00001, 2'd1, 2'b01};
    localparam logic [13:0] X_EBN  = {3'd2, 2'd0, 5'b00001, 2'd0, 2'b01};
    localparam logic [13:0] X_MLD  = {3'd3, 2'd0, 5'b01000, 2'd0, 2'b00};
    localparam logic [13:0] X_MST  = {3'd3, 2'd0, 5'b01100, 2'd0, 2'b00};
    localparam logic [13:0] X_MSTA = {3'd3, 2'd0, 5'b01101, 2'd0, 2'b01};
    localparam logic [13:0] X_WB0  = {3'd4, 2'd0, 5'b00001, 2'd0, 2'b11};
    localparam logic [13:0] X_WB1  = {3'd4, 2'd0, 5'b00001, 2'd1, 2'b11};
    localparam logic [13:0] X_WB2  = {3'd4, 2'd0, 5'b00001, 2'd2, 2'b11};
    localparam logic [13:0] X_H1   = {3'd5, 2'd1, 5'b00000, 2'd0, 2'b00};
    localparam logic [13:0] X_H2   = {3'd5, 2'd2, 5'b00000, 2'd0, 2'b00};
    localparam logic [13:0] X_H3   = {3'd5, 2'd3, 5'b00000, 2'd0, 2'b00};

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_SW    = 32'h00112023;
    localparam logic [31:0] I_BEQ   = 32'h00000463;
    localparam logic [31:0] I_JAL   = 32'h0000006F;
    localparam logic [31:0] I_JALR  = 32'h00000067;
    localparam logic [31:0] I_FENCE = 32'h0000000F;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_JUNK  = 32'hFFFFFFFF;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        #1;
        total++;
        if (obs !== X_RST) begin
            bad++;
            $display("FAIL reset_hold: got %h want %h", obs, X_RST);
        end
        rst_i = 1'b0;
        #1;
        total++;
        if (obs !== X_F0) begin
            bad++;
            $display("FAIL reset_release: got %h want %h", obs, X_F0);
        end
    endtask

    // ADDI; instruction bus is garbage outside FETCH/DECODE to show it is ignored.
    task automatic test_alu();
        logic [13:0] e [5];
        logic [3:0]  d [5];
        e = '{X_FA, X_D, X_E, X_WB0, X_F0};
        d = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            {rst_i, imem_ack_i, dmem_ack_i, branch_taken_i} = d[i];
            instruction_i = (i < 2) ? I_ADDI : I_JUNK;
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL addi cyc%0d: got %h want %h", i, obs, e[i]);
            end
            if (i != 4) step();
        end
    endtask

    task automatic test_load();
        logic [13:0] e [9];
        logic [3:0]  d [9];
        e = '{X_FA, X_D, X_E, X_MLD, X_MLD, X_MLD, X_MLD, X_WB0, X_F0};
        d = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
              4'b0010, 4'b0000, 4'b0000};
        for (int i = 0; i < 9; i++) begin
            {rst_i, imem_ack_i, dmem_ack_i, branch_taken_i} = d[i];
            instruction_i = (i < 2) ? I_LW : I_JUNK;
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL lw cyc%0d: got %h want %h", i, obs, e[i]);
            end
            if (i != 8) step();
        end
    endtask

    task automatic test_store();
        logic [13:0] e [6];
        logic [3:0]  d [6];
        e = '{X_FA, X_D, X_E, X_MST, X_MSTA, X_F0};
        d = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            {rst_i, imem_ack_i, dmem_ack_i, branch_taken_i} = d[i];
            instruction_i = (i < 2) ? I_SW : I_JUNK;
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL sw cyc%0d: got %h want %h", i, obs, e[i]);
            end
            if (i != 5) step();
        end
    endtask

    // BEQ taken then not taken; taken is driven opposite in DECODE to show it only matters in EXECUTE.
    task automatic test_branch();
        logic [13:0] e [8];
        logic [3:0]  d [8];
        e = '{X_FA, X_D, X_EBT, X_F0, X_D, X_EBN, X_F0, X_F0};
        d = '{4'b0100, 4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        e[3] = X_FA;
        for (int i = 0; i < 7; i++) begin
            {rst_i, imem_ack_i, dmem_ack_i, branch_taken_i} = d[i];
            instruction_i = (i == 0 || i == 1 || i == 3 || i == 4) ? I_BEQ : I_JUNK;
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL beq cyc%0d: got %h want %h", i, obs, e[i]);
            end
            if (i != 6) step();
        end
    endtask

    task automatic test_jump();
        logic [13:0] e [9];
        logic [3:0]  d [9];
        e = '{X_FA, X_D, X_E, X_WB1, X_FA, X_D, X_E, X_WB2, X_F0};
        d = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000,
              4'b0000, 4'b0000};
        for (int i = 0; i < 9; i++) begin
            {rst_i, imem_ack_i, dmem_ack_i, branch_taken_i} = d[i];
            instruction_i = (i < 2) ? I_JAL : ((i == 4 || i == 5) ? I_JALR : I_JUNK);
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL jump cyc%0d: got %h want %h", i, obs, e[i]);
            end
            if (i != 8) step();
        end
    endtask

    task automatic test_fence();
        logic [13:0] e [4];
        logic [3:0]  d [4];
        e = '{X_FA, X_D, X_EBN, X_F0};
        d = '{4'b0100, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            {rst_i, imem_ack_i, dmem_ack_i, branch_taken_i} = d[i];
            instruction_i = (i < 2) ? I_FENCE : I_JUNK;
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL fence cyc%0d: got %h want %h", i, obs, e[i]);
            end
            if (i != 3) step();
        end
    endtask

    // Reset pulse while a load waits on dmem, with ack arriving in the reset cycle.
    task automatic test_reset_mid();
        logic [13:0] e [6];
        logic [3:0]  d [6];
        e = '{X_FA, X_D, X_E, X_MLD, X_RST, X_F0};
        d = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            {rst_i, imem_ack_i, dmem_ack_i, branch_taken_i} = d[i];
            instruction_i = (i < 2) ? I_LW : I_JUNK;
            #1;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL rst_mid cyc%0d: got %h want %h", i, obs, e[i]);
            end
            if (i != 5) step();
        end
    endtask

    task automatic test_timeout();
        logic [13:0] ex;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
`ifdef CORE_CTRL_TIMEOUT_EN
        for (int i = 0; i < 18; i++) begin
            ex = (i < 15) ? X_F0 : X_H2;
            #1;
            total++;
            if (obs !== ex) begin
                bad++;
                $display("FAIL timeout cyc%0d: got %h want %h", i, obs, ex);
            end
            step();
        end
`else
        ex = X_F0;
        for (int i = 0; i <= 100; i++) begin
            if (i == 0 || i == 15 || i == 16 || i == 100) begin
                #1;
                total++;
                if (obs !== ex) begin
                    bad++;
                    $display("FAIL no_timeout cyc%0d: got %h want %h", i, obs, ex);
                end
            end
            step();
        end
`endif
        do_reset();
    endtask

    // Illegal opcode then ECALL; HALT must ignore a held imem ack.
    task automatic test_faults();
        logic [13:0] ex;
        for (int i = 0; i < 23; i++) begin
            imem_ack_i    = (i == 0) || (i >= 3);
            instruction_i = 32'h00000000;
            ex = (i == 0) ? X_FA : ((i == 1) ? X_D : X_H1);
            #1;
            total++;
            if (obs !== ex) begin
                bad++;
                $display("FAIL illegal cyc%0d: got %h want %h", i, obs, ex);
            end
            step();
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            imem_ack_i    = (i == 0);
            instruction_i = (i < 2) ? I_ECALL : I_JUNK;
            ex = (i == 0) ? X_FA : ((i == 1) ? X_D : X_H3);
            #1;
            total++;
            if (obs !== ex) begin
                bad++;
                $display("FAIL ecall cyc%0d: got %h want %h", i, obs, ex);
            end
            step();
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_jump();
        test_fence();
        test_reset_mid();
        test_timeout();
        test_faults();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
